// File: rtl/npm_rr_dma.sv
// npm_rr_dma: round-robin arbiter over NUM_CH NP cores driving linear AXI4 INCR bursts.
// Optional macro NPM_4K_SPLIT_EN additionally caps each burst at the next 4KB boundary.
module npm_rr_dma #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 32,
    parameter int MAX_BURST = 256
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        req,
    output logic [NUM_CH-1:0]        gnt,
    input  logic [NUM_CH-1:0]        rwn,
    input  logic [NUM_CH*ADDR_W-1:0] adr,
    input  logic [NUM_CH*LEN_W-1:0]  len,
    input  logic [NUM_CH*DATA_W-1:0] wdt,
    output logic [DATA_W-1:0]        rdt,
    output logic [NUM_CH-1:0]        ack,
    output logic [NUM_CH-1:0]        done,
    output logic                     err,
    output logic [ADDR_W-1:0]        m_axi_awaddr,
    output logic [7:0]               m_axi_awlen,
    output logic [2:0]               m_axi_awsize,
    output logic [1:0]               m_axi_awburst,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [DATA_W-1:0]        m_axi_wdata,
    output logic [DATA_W/8-1:0]      m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic [ADDR_W-1:0]        m_axi_araddr,
    output logic [7:0]               m_axi_arlen,
    output logic [2:0]               m_axi_arsize,
    output logic [1:0]               m_axi_arburst,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [DATA_W-1:0]        m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rlast,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SZ   = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {IDLE = 3'd0, ADDR = 3'd1, DATA = 3'd2, RESP = 3'd3, FIN = 3'd4} state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t              st_r;
    logic [CH_W-1:0]     ptr_r, own_r, win_s;
    logic [CH_W:0]       cand_s;
    logic                win_vld_s, rwn_r, avalid_r, wvalid_r, rready_r, bready_r, err_r;
    logic [ADDR_W-1:0]   addr_r, sel_adr_s;
    logic [LEN_W-1:0]    rem_r, sel_len_s;
    logic                sel_rwn_s;
    logic [8:0]          blen_s, blen_cap_s, blen_r, beat_r;
    logic [DATA_W-1:0]   wdata_s;
    logic [NUM_CH-1:0]   gnt_r, done_r;
    logic                whs_s, rhs_s;
`ifdef NPM_4K_SPLIT_EN
    logic [12:0]         bnd_s;
`endif

    // Round-robin search: lowest offset from the pointer with an active request wins.
    always_comb begin
        win_vld_s = 1'b0;
        win_s     = '0;
        cand_s    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand_s    = {1'b0, ptr_r} + (CH_W+1)'(i);
            cand_s    = (cand_s >= (CH_W+1)'(NUM_CH)) ? cand_s - (CH_W+1)'(NUM_CH) : cand_s;
            win_vld_s = win_vld_s | req[cand_s[CH_W-1:0]];
            win_s     = req[cand_s[CH_W-1:0]] ? cand_s[CH_W-1:0] : win_s;
        end
    end

    // Per-channel field muxes for the winner (latched) and the owner (write data).
    always_comb begin
        sel_rwn_s = 1'b0;
        sel_adr_s = '0;
        sel_len_s = '0;
        wdata_s   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_rwn_s = (win_s == CH_W'(i)) ? rwn[i] : sel_rwn_s;
            sel_adr_s = (win_s == CH_W'(i)) ? adr[i*ADDR_W +: ADDR_W] : sel_adr_s;
            sel_len_s = (win_s == CH_W'(i)) ? len[i*LEN_W +: LEN_W] : sel_len_s;
            wdata_s   = (own_r == CH_W'(i)) ? wdt[i*DATA_W +: DATA_W] : wdata_s;
        end
    end

    // Next burst length from the current address/remaining registers.
    always_comb begin
        blen_cap_s = (rem_r > LEN_W'(MAX_BURST)) ? 9'(MAX_BURST) : rem_r[8:0];
`ifdef NPM_4K_SPLIT_EN
        bnd_s  = (13'd4096 - {1'b0, addr_r[11:0]}) >> SZ;
        blen_s = ({4'd0, blen_cap_s} > bnd_s) ? bnd_s[8:0] : blen_cap_s;
`else
        blen_s = blen_cap_s;
`endif
    end

    assign whs_s = wvalid_r & m_axi_wready;
    assign rhs_s = rready_r & m_axi_rvalid;

    // Address/length outputs derive only from registers, so they stay put while valid is held.
    assign m_axi_awvalid = avalid_r & ~rwn_r;
    assign m_axi_arvalid = avalid_r & rwn_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_awlen   = m_axi_awvalid ? 8'(blen_s - 9'd1) : 8'd0;
    assign m_axi_arlen   = m_axi_arvalid ? 8'(blen_s - 9'd1) : 8'd0;
    assign m_axi_awsize  = m_axi_awvalid ? 3'(SZ) : 3'd0;
    assign m_axi_arsize  = m_axi_arvalid ? 3'(SZ) : 3'd0;
    assign m_axi_awburst = m_axi_awvalid ? 2'b01 : 2'b00;
    assign m_axi_arburst = m_axi_arvalid ? 2'b01 : 2'b00;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_wdata   = wvalid_r ? wdata_s : '0;
    assign m_axi_wstrb   = {(DATA_W/8){wvalid_r}};
    assign m_axi_wlast   = wvalid_r & (beat_r == blen_r - 9'd1);
    assign m_axi_rready  = rready_r;
    assign m_axi_bready  = bready_r;
    assign rdt           = m_axi_rdata;
    assign ack           = onehot(own_r) & {NUM_CH{whs_s | rhs_s}};
    assign gnt           = gnt_r;
    assign done          = done_r;
    assign err           = err_r;

    // Transfer FSM with arbitration, burst bookkeeping and registered status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_r     <= IDLE;
            ptr_r    <= '0;
            own_r    <= '0;
            rwn_r    <= 1'b0;
            addr_r   <= '0;
            rem_r    <= '0;
            blen_r   <= '0;
            beat_r   <= '0;
            avalid_r <= 1'b0;
            wvalid_r <= 1'b0;
            rready_r <= 1'b0;
            bready_r <= 1'b0;
            err_r    <= 1'b0;
            gnt_r    <= '0;
            done_r   <= '0;
        end else begin
            gnt_r  <= '0;
            done_r <= '0;
            case (st_r)
                IDLE: begin
                    if (win_vld_s) begin
                        st_r     <= ADDR;
                        own_r    <= win_s;
                        ptr_r    <= (win_s == CH_W'(NUM_CH - 1)) ? '0 : win_s + CH_W'(1);
                        rwn_r    <= sel_rwn_s;
                        addr_r   <= sel_adr_s;
                        rem_r    <= sel_len_s;
                        err_r    <= 1'b0;
                        gnt_r    <= onehot(win_s);
                        avalid_r <= (sel_len_s != '0);
                    end else begin
                        st_r <= IDLE;
                    end
                end
                ADDR: begin
                    if (rem_r == '0) begin
                        st_r <= FIN;
                    end else if (avalid_r & (rwn_r ? m_axi_arready : m_axi_awready)) begin
                        st_r     <= DATA;
                        avalid_r <= 1'b0;
                        addr_r   <= addr_r + (ADDR_W'(blen_s) << SZ);
                        rem_r    <= rem_r - LEN_W'(blen_s);
                        blen_r   <= blen_s;
                        beat_r   <= '0;
                        wvalid_r <= ~rwn_r;
                        rready_r <= rwn_r;
                    end else begin
                        st_r <= ADDR;
                    end
                end
                DATA: begin
                    if (whs_s) begin
                        beat_r <= beat_r + 9'd1;
                        if (m_axi_wlast) begin
                            wvalid_r <= 1'b0;
                            bready_r <= 1'b1;
                            st_r     <= RESP;
                        end else begin
                            st_r <= DATA;
                        end
                    end else if (rhs_s) begin
                        err_r <= err_r | (m_axi_rresp != 2'b00);
                        if (m_axi_rlast) begin
                            rready_r <= 1'b0;
                            avalid_r <= (rem_r != '0);
                            st_r     <= (rem_r == '0) ? FIN : ADDR;
                        end else begin
                            st_r <= DATA;
                        end
                    end else begin
                        st_r <= DATA;
                    end
                end
                RESP: begin
                    if (bready_r & m_axi_bvalid) begin
                        bready_r <= 1'b0;
                        err_r    <= err_r | (m_axi_bresp != 2'b00);
                        avalid_r <= (rem_r != '0);
                        st_r     <= (rem_r == '0) ? FIN : ADDR;
                    end else begin
                        st_r <= RESP;
                    end
                end
                FIN: begin
                    done_r <= onehot(own_r);
                    st_r   <= IDLE;
                end
                default: begin
                    st_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npm_rr_dma.sv
// Directed bench for npm_rr_dma: table of single transfers plus round-robin, len=0 and reset sequences.
module tb_npm_rr_dma;
    localparam int NUM_CH = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 32, MAX_BURST = 256;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]        req, gnt, rwn, ack, done;
    logic [NUM_CH*ADDR_W-1:0] adr;
    logic [NUM_CH*LEN_W-1:0]  len;
    logic [NUM_CH*DATA_W-1:0] wdt;
    logic [DATA_W-1:0]        rdt;
    logic                     err;
    logic [ADDR_W-1:0]        awaddr, araddr;
    logic [7:0]               awlen, arlen;
    logic [2:0]               awsize, arsize;
    logic [1:0]               awburst, arburst, bresp, rresp;
    logic                     awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic                     arvalid, arready, rlast, rvalid, rready;
    logic [DATA_W-1:0]        wdata, rdata;
    logic [DATA_W/8-1:0]      wstrb;

    npm_rr_dma #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .rwn(rwn), .adr(adr), .len(len), .wdt(wdt),
        .rdt(rdt), .ack(ack), .done(done), .err(err),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Slave configuration, set by the stimulus process only.
    int         ar_dly = 0, aw_dly = 0;
    bit         w_tog = 1'b0;
    logic [1:0] bresp_mode = 2'b00;

    // Slave state and logs.
    int          acnt_ar, acnt_aw, w_cnt, w_blen, r_left;
    logic [31:0] r_addr;
    int          nb = 0, wn = 0, wlast_bad = 0, proto_bad = 0;
    logic [31:0] blog_adr[256];
    int          blog_len[256];
    logic [31:0] wlog[1024];

    // Monitor state.
    int          ack_cnt[NUM_CH], done_cnt[NUM_CH];
    int          cyc = 0, gnt_cyc = 0, done_cyc = 0, nvalid = 0, onehot_bad = 0, stab_bad = 0;
    logic        prev_aw, prev_w;
    logic [31:0] prev_awaddr, prev_wdata;

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            ack_cnt[c]  = 0;
            done_cnt[c] = 0;
        end
    end

    // Write data per core advances after each of its acks.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_wdt
        assign wdt[g*DATA_W +: DATA_W] = 32'hC000_0000 + (32'(g) << 16) + 32'(ack_cnt[g]);
    end

    // AXI slave model: delayed address ready, optional toggling wready, programmable bresp.
    always @(posedge clk) begin
        if (!rstn) begin
            arready <= 1'b0; awready <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0; rdata <= 32'd0;
            rresp <= 2'b00; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            acnt_ar <= 0; acnt_aw <= 0; w_cnt <= 0; w_blen <= 0; r_left <= 0; r_addr <= 32'd0;
        end else begin
            if (arvalid && arready) begin
                arready <= 1'b0;
                rvalid  <= 1'b1;
                rdata   <= araddr ^ 32'h5A5A_0000;
                rlast   <= (arlen == 8'd0);
                r_addr  <= araddr + 32'd4;
                r_left  <= int'(arlen);
                if (nb < 256) begin blog_adr[nb] <= araddr; blog_len[nb] <= int'(arlen); end
                nb <= nb + 1;
                if (arsize != 3'd2 || arburst != 2'b01) proto_bad <= proto_bad + 1;
            end else if (arvalid) begin
                if (acnt_ar >= ar_dly) begin arready <= 1'b1; acnt_ar <= 0; end
                else acnt_ar <= acnt_ar + 1;
            end
            if (rvalid && rready) begin
                if (rlast) begin
                    rvalid <= 1'b0;
                    rlast  <= 1'b0;
                end else begin
                    rdata  <= r_addr ^ 32'h5A5A_0000;
                    r_addr <= r_addr + 32'd4;
                    rlast  <= (r_left == 1);
                    r_left <= r_left - 1;
                end
            end
            if (awvalid && awready) begin
                awready <= 1'b0;
                w_blen  <= int'(awlen);
                w_cnt   <= 0;
                if (nb < 256) begin blog_adr[nb] <= awaddr; blog_len[nb] <= int'(awlen); end
                nb <= nb + 1;
                if (awsize != 3'd2 || awburst != 2'b01) proto_bad <= proto_bad + 1;
            end else if (awvalid) begin
                if (acnt_aw >= aw_dly) begin awready <= 1'b1; acnt_aw <= 0; end
                else acnt_aw <= acnt_aw + 1;
            end
            wready <= w_tog ? ~wready : 1'b1;
            if (wvalid && wready) begin
                if (wn < 1024) wlog[wn] <= wdata;
                wn <= wn + 1;
                if (wlast != (w_cnt == w_blen)) wlast_bad <= wlast_bad + 1;
                if (wstrb != 4'hF) proto_bad <= proto_bad + 1;
                if (wlast) begin
                    w_cnt  <= 0;
                    bvalid <= 1'b1;
                    bresp  <= bresp_mode;
                end else begin
                    w_cnt <= w_cnt + 1;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
        end
    end

    // Monitor: ack/done/grant bookkeeping and valid-hold stability.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ack[c])  ack_cnt[c]  <= ack_cnt[c] + 1;
            if (done[c]) done_cnt[c] <= done_cnt[c] + 1;
        end
        if (gnt != 4'd0) begin
            gnt_cyc <= cyc;
            if ($countones(gnt) != 1) onehot_bad <= onehot_bad + 1;
        end
        if (done != 4'd0) done_cyc <= cyc;
        if (awvalid || arvalid || wvalid) nvalid <= nvalid + 1;
        if (!rstn) begin
            prev_aw <= 1'b0;
            prev_w  <= 1'b0;
        end else begin
            if (prev_aw && (!awvalid || awaddr != prev_awaddr)) stab_bad <= stab_bad + 1;
            if (prev_w && (!wvalid || wdata != prev_wdata)) stab_bad <= stab_bad + 1;
            prev_aw     <= awvalid & ~awready;
            prev_awaddr <= awaddr;
            prev_w      <= wvalid & ~wready;
            prev_wdata  <= wdata;
        end
    end

    int checks = 0, failures = 0;
    bit err_at_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input int ch, input bit rd, input logic [31:0] a, input int l);
        int t;
        @(negedge clk);
        rwn[ch] = rd;
        adr[ch*ADDR_W +: ADDR_W] = a;
        len[ch*LEN_W +: LEN_W]   = l;
        req[ch] = 1'b1;
        t = 0;
        while (!gnt[ch] && t < 100) begin @(negedge clk); t++; end
        req[ch] = 1'b0;
        check("gnt_seen", 64'(gnt[ch]), 64'd1);
        t = 0;
        while (!done[ch] && t < 20000) begin @(negedge clk); t++; end
        err_at_done = err;
        check("done_seen", 64'(done[ch]), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int ch; bit rd; logic [31:0] a; int l; logic [1:0] br; int dly; bit tog;
        int nb; int len0; logic [31:0] adr0; int lenl; logic [31:0] adrl; bit e;
    } vec_t;
    vec_t vt[6];

    logic [3:0]  gseq[5];
    logic [31:0] wexp;
    int nb0, wn0, ack0, done0, stab0, wl0, pr0, nv0, seen, t, li;

    initial begin
        vt[0] = '{0, 1'b1, 32'h1000, 600, 2'b00, 0, 1'b0, 3, 255, 32'h1000, 87, 32'h1800, 1'b0};
        vt[1] = '{2, 1'b0, 32'h2000, 4,   2'b10, 0, 1'b0, 1, 3,   32'h2000, 3,  32'h2000, 1'b1};
        vt[2] = '{1, 1'b0, 32'h3000, 4,   2'b00, 0, 1'b0, 1, 3,   32'h3000, 3,  32'h3000, 1'b0};
`ifdef NPM_4K_SPLIT_EN
        vt[3] = '{3, 1'b1, 32'h0FF0, 8,   2'b00, 0, 1'b0, 2, 3,   32'h0FF0, 3,  32'h1000, 1'b0};
`else
        vt[3] = '{3, 1'b1, 32'h0FF0, 8,   2'b00, 0, 1'b0, 1, 7,   32'h0FF0, 7,  32'h0FF0, 1'b0};
`endif
        vt[4] = '{1, 1'b0, 32'h4000, 10,  2'b00, 5, 1'b1, 1, 9,   32'h4000, 9,  32'h4000, 1'b0};
        vt[5] = '{0, 1'b0, 32'h8000, 300, 2'b00, 0, 1'b0, 2, 255, 32'h8000, 43, 32'h8400, 1'b0};

        req = '0; rwn = '0; adr = '0; len = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl", 64'({gnt, ack, done, err, awvalid, arvalid, wvalid, rready, bready, wlast, awlen, arlen}), 64'd0);
        check("reset_addr", 64'({awaddr, araddr}), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Round robin with every core requesting continuously.
        for (int k = 0; k < 5; k++) gseq[k] = 4'd0;
        rwn = 4'hF;
        for (int c = 0; c < NUM_CH; c++) begin
            adr[c*ADDR_W +: ADDR_W] = 32'h100 * c;
            len[c*LEN_W +: LEN_W]   = 1;
        end
        req = 4'hF;
        seen = 0; t = 0;
        while (seen < 5 && t < 300) begin
            @(negedge clk); t++;
            if (gnt != 4'd0) begin
                gseq[seen] = gnt;
                seen++;
                if (seen == 5) req = 4'h0;
            end
        end
        req = 4'h0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 5; k++) check($sformatf("rr_gnt%0d", k), 64'(gseq[k]), 64'(4'b0001 << (k % 4)));
        check("gnt_onehot", 64'(onehot_bad), 64'd0);

        // Table of single transfers.
        for (int v = 0; v < 6; v++) begin
            ar_dly = vt[v].dly; aw_dly = vt[v].dly; w_tog = vt[v].tog; bresp_mode = vt[v].br;
            nb0 = nb; wn0 = wn; ack0 = ack_cnt[vt[v].ch]; done0 = done_cnt[vt[v].ch];
            stab0 = stab_bad; wl0 = wlast_bad; pr0 = proto_bad;
            run_xfer(vt[v].ch, vt[v].rd, vt[v].a, vt[v].l);
            li = (nb > nb0) ? nb - 1 : 0;
            check($sformatf("v%0d_nburst", v), 64'(nb - nb0), 64'(vt[v].nb));
            check($sformatf("v%0d_len0", v), 64'(blog_len[nb0]), 64'(vt[v].len0));
            check($sformatf("v%0d_adr0", v), 64'(blog_adr[nb0]), 64'(vt[v].adr0));
            check($sformatf("v%0d_lenl", v), 64'(blog_len[li]), 64'(vt[v].lenl));
            check($sformatf("v%0d_adrl", v), 64'(blog_adr[li]), 64'(vt[v].adrl));
            check($sformatf("v%0d_acks", v), 64'(ack_cnt[vt[v].ch] - ack0), 64'(vt[v].l));
            check($sformatf("v%0d_done", v), 64'(done_cnt[vt[v].ch] - done0), 64'd1);
            check($sformatf("v%0d_err", v), 64'(err_at_done), 64'(vt[v].e));
            check($sformatf("v%0d_proto", v), 64'((stab_bad - stab0) + (wlast_bad - wl0) + (proto_bad - pr0)), 64'd0);
            if (!vt[v].rd) begin
                check($sformatf("v%0d_wbeats", v), 64'(wn - wn0), 64'(vt[v].l));
                wexp = 32'hC000_0000 + (32'(vt[v].ch) << 16) + 32'(ack0);
                check($sformatf("v%0d_wfirst", v), 64'(wlog[wn0]), 64'(wexp));
                check($sformatf("v%0d_wlastd", v), 64'(wlog[wn - 1]), 64'(wexp + 32'(vt[v].l - 1)));
            end
        end
        ar_dly = 0; aw_dly = 0; w_tog = 1'b0; bresp_mode = 2'b00;

        // Zero-length request: no AXI traffic, done two cycles after gnt.
        nv0 = nvalid; nb0 = nb; done0 = done_cnt[3];
        run_xfer(3, 1'b0, 32'h0, 0);
        check("len0_latency", 64'(done_cyc - gnt_cyc), 64'd2);
        check("len0_valids", 64'(nvalid - nv0), 64'd0);
        check("len0_done", 64'(done_cnt[3] - done0), 64'd1);

        // Reset in the middle of a write burst.
        @(negedge clk);
        rwn[0] = 1'b0; adr[0 +: ADDR_W] = 32'h5000; len[0 +: LEN_W] = 20; req[0] = 1'b1;
        t = 0;
        while (!gnt[0] && t < 100) begin @(negedge clk); t++; end
        req[0] = 1'b0;
        ack0 = ack_cnt[0]; t = 0;
        while ((ack_cnt[0] - ack0) < 3 && t < 200) begin @(negedge clk); t++; end
        check("mid_reset_reached", 64'(wvalid), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_reset_out", 64'({gnt, ack, done, err, awvalid, arvalid, wvalid, rready, bready, wlast}), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        nb0 = nb; ack0 = ack_cnt[1]; done0 = done_cnt[1];
        run_xfer(1, 1'b1, 32'h100, 5);
        check("post_reset_acks", 64'(ack_cnt[1] - ack0), 64'd5);
        check("post_reset_done", 64'(done_cnt[1] - done0), 64'd1);
        check("post_reset_err", 64'(err_at_done), 64'd0);
        check("post_reset_arlen", 64'(blog_len[nb0]), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
